bf16_partial_accumulator: RTL

Downstream companion to the 16-way FP8 MAC. It consumes the MAC's BF16 partial dot-products (one per `din_valid` beat), sums `K_TILES` consecutive beats in a widened floating-point accumulator, and rounds each completed group once to BF16. Each result is presented on a valid/ready output port. With this block, a dot-product longer than 16 elements becomes a single BF16 result without per-tile double rounding.

---
 rtl/bf16_acc_pkg.sv | 20 ++
 rtl/bf16_round_rne.sv | 48 ++++
 rtl/bf16_partial_accumulator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bf16_acc_pkg.sv
// Shared types and constants for the BF16 partial-sum accumulator.
// Imported by the rounding sub-module and the accumulator top level.
package bf16_acc_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } acc_state_e;

    localparam logic [15:0] BF16_MAX_POS = 16'h7F7F;
    localparam logic [15:0] BF16_ZERO    = 16'h0000;
    localparam logic [7:0]  EXP_MAX      = 8'd254;

endpackage

// File: rtl/bf16_round_rne.sv
// Rounds a widened sign/exponent/mantissa value to BF16 (round-to-nearest-even).
// Ports: sign_i, exp_i (0 = zero), man_i (normalized, hidden bit at MSB) -> bf16_o.
module bf16_round_rne
    import bf16_acc_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             sign_i,
    input  logic [7:0]       exp_i,
    input  logic [ACC_W-1:0] man_i,
    output logic [15:0]      bf16_o
);

    localparam int RW = ACC_W - 8;
    localparam logic [RW-1:0] HALF = RW'(1) << (RW - 1);

    logic [7:0]    keep;
    logic [RW-1:0] rest;
    logic          up;
    logic [8:0]    sum9;
    logic [8:0]    e9;
    logic [6:0]    frac;
    bf16_t         res;

    assign keep = man_i[ACC_W-1 -: 8];
    assign rest = man_i[RW-1:0];
    assign up   = (rest > HALF) || ((rest == HALF) && keep[0]);
    assign sum9 = {1'b0, keep} + {8'd0, up};
    // A carry out of the kept bits means the mantissa rolled to 1.0
    assign e9   = {1'b0, exp_i} + {8'd0, sum9[8]};
    assign frac = sum9[8] ? 7'd0 : sum9[6:0];

    always_comb begin
        res = BF16_ZERO;
        if (exp_i == 8'd0) begin
            res = BF16_ZERO;
        end else if (e9 > {1'b0, EXP_MAX}) begin
            res = {sign_i, BF16_MAX_POS[14:0]};
        end else begin
            res.sign = sign_i;
            res.exp  = e9[7:0];
            res.man  = frac;
        end
    end

    assign bf16_o = res;

endmodule

// File: rtl/bf16_partial_accumulator.sv
// Sums K_TILES BF16 beats in a widened accumulator, rounds each group once.
// Ports: clk/rst, din/din_valid in, dout/dout_valid/dout_ready out, beat_cnt, drop_flag.
module bf16_partial_accumulator
    import bf16_acc_pkg::*;
#(
    parameter int K_TILES = 4,
    parameter int ACC_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  din,
    input  logic                         din_valid,
    output logic [15:0]                  dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(K_TILES+1)-1:0] beat_cnt,
    output logic                         drop_flag
);

    localparam int CW = $clog2(K_TILES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(K_TILES - 1);

    acc_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_s_q, acc_s_d;
    logic [7:0]       acc_e_q, acc_e_d;
    logic [ACC_W-1:0] acc_m_q, acc_m_d;
    logic             fin_s_q, fin_s_d;
    logic [7:0]       fin_e_q, fin_e_d;
    logic [ACC_W-1:0] fin_m_q, fin_m_d;
    logic             fin_v_q, fin_v_d;
    logic [15:0]      dout_q, dout_d;
    logic             dout_v_q, dout_v_d;
    logic             drop_q, drop_d;

    // Input decode: zero exponent is zero, 255 saturates to 254
    bf16_t            din_b;
    logic             in_s;
    logic [7:0]       in_e;
    logic [ACC_W-1:0] in_m;

    assign din_b = din;

    always_comb begin
        in_s = 1'b0;
        in_e = 8'd0;
        in_m = '0;
        if (din_b.exp != 8'd0) begin
            in_s = din_b.sign;
            in_e = (din_b.exp == 8'hFF) ? EXP_MAX : din_b.exp;
            in_m = {1'b1, din_b.man, {(ACC_W-8){1'b0}}};
        end
    end

    // Align, add/subtract, renormalize
    logic             a_big;
    logic             big_s, sml_s;
    logic [7:0]       big_e, sml_e, shamt;
    logic [ACC_W-1:0] big_m, sml_m, sml_al;
    logic [ACC_W:0]   sum;
    logic [7:0]       lz;
    logic             found;
    logic             res_s;
    logic [7:0]       res_e;
    logic [ACC_W-1:0] res_m;

    always_comb begin
        a_big = (acc_e_q > in_e) ||
                ((acc_e_q == in_e) && (acc_m_q >= in_m));
        big_s = a_big ? acc_s_q : in_s;
        big_e = a_big ? acc_e_q : in_e;
        big_m = a_big ? acc_m_q : in_m;
        sml_s = a_big ? in_s : acc_s_q;
        sml_e = a_big ? in_e : acc_e_q;
        sml_m = a_big ? in_m : acc_m_q;
        shamt = big_e - sml_e;
        sml_al = (int'(shamt) >= ACC_W) ? '0 : (sml_m >> shamt);
        if (big_s == sml_s) begin
            sum = {1'b0, big_m} + {1'b0, sml_al};
        end else begin
            sum = {1'b0, big_m} - {1'b0, sml_al};
        end

        lz    = 8'd0;
        found = 1'b0;
        for (int i = ACC_W - 1; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 8'(ACC_W - 1 - i);
                found = 1'b1;
            end
        end

        res_s = 1'b0;
        res_e = 8'd0;
        res_m = '0;
        if (sum == '0) begin
            res_s = 1'b0;
        end else if (sum[ACC_W]) begin
            // Exponent pins at 255; rounding saturates it anyway
            res_s = big_s;
            res_e = (big_e == 8'hFF) ? 8'hFF : big_e + 8'd1;
            res_m = sum[ACC_W:1];
        end else if ({1'b0, lz} < {1'b0, big_e}) begin
            res_s = big_s;
            res_e = big_e - lz;
            res_m = sum[ACC_W-1:0] << lz;
        end
    end

    // Counter, accumulator and fin capture
    logic             first, last;
    logic             nxt_s;
    logic [7:0]       nxt_e;
    logic [ACC_W-1:0] nxt_m;

    assign first = (cnt_q == '0);
    assign last  = (cnt_q == LAST_CNT);
    assign nxt_s = first ? in_s : res_s;
    assign nxt_e = first ? in_e : res_e;
    assign nxt_m = first ? in_m : res_m;

    always_comb begin
        cnt_d   = cnt_q;
        acc_s_d = acc_s_q;
        acc_e_d = acc_e_q;
        acc_m_d = acc_m_q;
        fin_s_d = fin_s_q;
        fin_e_d = fin_e_q;
        fin_m_d = fin_m_q;
        fin_v_d = 1'b0;
        if (din_valid) begin
            if (last) begin
                fin_s_d = nxt_s;
                fin_e_d = nxt_e;
                fin_m_d = nxt_m;
                fin_v_d = 1'b1;
                cnt_d   = '0;
                acc_s_d = 1'b0;
                acc_e_d = 8'd0;
                acc_m_d = '0;
            end else begin
                acc_s_d = nxt_s;
                acc_e_d = nxt_e;
                acc_m_d = nxt_m;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (din_valid && !last) state_d = S_ACC;
            S_ACC:  if (din_valid && last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Round stage feeding the output register
    logic [15:0] rnd;
    logic        load;

    bf16_round_rne #(
        .ACC_W (ACC_W)
    ) u_round (
        .sign_i (fin_s_q),
        .exp_i  (fin_e_q),
        .man_i  (fin_m_q),
        .bf16_o (rnd)
    );

    assign load = fin_v_q && (!dout_v_q || dout_ready);

    always_comb begin
        dout_d   = load ? rnd : dout_q;
        dout_v_d = load ? 1'b1 : (dout_ready ? 1'b0 : dout_v_q);
        drop_d   = drop_q | (fin_v_q & ~load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_s_q  <= 1'b0;
            acc_e_q  <= 8'd0;
            acc_m_q  <= '0;
            fin_s_q  <= 1'b0;
            fin_e_q  <= 8'd0;
            fin_m_q  <= '0;
            fin_v_q  <= 1'b0;
            dout_q   <= BF16_ZERO;
            dout_v_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_s_q  <= acc_s_d;
            acc_e_q  <= acc_e_d;
            acc_m_q  <= acc_m_d;
            fin_s_q  <= fin_s_d;
            fin_e_q  <= fin_e_d;
            fin_m_q  <= fin_m_d;
            fin_v_q  <= fin_v_d;
            dout_q   <= dout_d;
            dout_v_q <= dout_v_d;
            drop_q   <= drop_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_v_q;
    assign beat_cnt   = cnt_q;
    assign drop_flag  = drop_q;

endmodule
